// File: rtl/mips8_controller.sv
`default_nettype none
// ============================================================================
// Module   : mips8_controller
// Function : Multicycle control unit for the 8-bit MIPS datapath: Moore FSM
//            with registered strobes plus an embedded ALU decoder.
// Revision : 1.0 - initial release
// ============================================================================
module mips8_controller #(
    parameter logic [5:0] OP_LB    = 6'b100000,
    parameter logic [5:0] OP_SB    = 6'b101000,
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter logic [5:0] OP_ADDI  = 6'b001000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       memread,
    output logic       memwrite,
    output logic       alusrca,
    output logic       memtoreg,
    output logic       regdst,
    output logic       iord,
    output logic       pcen,
    output logic       regwrite,
    output logic [1:0] pcsrc,
    output logic [1:0] alusrcb,
    output logic [3:0] irwrite,
    output logic [2:0] alucontrol
);

    typedef enum logic [3:0] {
        FETCH1  = 4'd0,
        FETCH2  = 4'd1,
        FETCH3  = 4'd2,
        FETCH4  = 4'd3,
        DECODE  = 4'd4,
        MEMADR  = 4'd5,
        LBRD    = 4'd6,
        LBWR    = 4'd7,
        SBWR    = 4'd8,
        RTYPEEX = 4'd9,
        RTYPEWR = 4'd10,
        BEQEX   = 4'd11,
        JEX     = 4'd12,
        ADDIEX  = 4'd13,
        ADDIWR  = 4'd14
    } state_t;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       alusrca;
        logic       memtoreg;
        logic       regdst;
        logic       iord;
        logic       pcwrite;
        logic       pcwritecond;
        logic       regwrite;
        logic [1:0] pcsrc;
        logic [1:0] alusrcb;
        logic [3:0] irwrite;
        logic       alu_funct;
        logic       alu_sub;
    } ctrl_t;

    localparam logic [2:0] c_ALU_AND = 3'b000;
    localparam logic [2:0] c_ALU_OR  = 3'b001;
    localparam logic [2:0] c_ALU_ADD = 3'b010;
    localparam logic [2:0] c_ALU_SUB = 3'b110;
    localparam logic [2:0] c_ALU_SLT = 3'b111;

    state_t r_state;
    state_t w_next;
    ctrl_t  r_ctrl;
    logic   r_is_store;
    logic [2:0] w_alu;

    // Strobe set for each state; registered against the next state so that
    // the outputs present during a state come straight from flops.
    function automatic ctrl_t f_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH1, FETCH2, FETCH3, FETCH4: begin
                c.memread = 1'b1;
                c.alusrcb = 2'b01;
                c.pcwrite = 1'b1;
                c.irwrite = 4'b0001 << s[1:0];
            end
            DECODE: c.alusrcb = 2'b11;
            MEMADR, ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            LBRD: begin
                c.memread = 1'b1;
                c.iord    = 1'b1;
            end
            LBWR: begin
                c.regwrite = 1'b1;
                c.memtoreg = 1'b1;
            end
            SBWR: begin
                c.memwrite = 1'b1;
                c.iord     = 1'b1;
            end
            RTYPEEX: begin
                c.alusrca   = 1'b1;
                c.alu_funct = 1'b1;
            end
            RTYPEWR: begin
                c.regwrite = 1'b1;
                c.regdst   = 1'b1;
            end
            BEQEX: begin
                c.alusrca     = 1'b1;
                c.alu_sub     = 1'b1;
                c.pcsrc       = 2'b01;
                c.pcwritecond = 1'b1;
            end
            JEX: begin
                c.pcwrite = 1'b1;
                c.pcsrc   = 2'b10;
            end
            ADDIWR: c.regwrite = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] f_alu_decode(input logic [5:0] f);
        logic [2:0] a;
        case (f)
            6'b100000: a = c_ALU_ADD;
            6'b100010: a = c_ALU_SUB;
            6'b100100: a = c_ALU_AND;
            6'b100101: a = c_ALU_OR;
            6'b101010: a = c_ALU_SLT;
            default:   a = c_ALU_ADD;
        endcase
        return a;
    endfunction

    always_comb begin
        w_next = FETCH1;
        case (r_state)
            FETCH1:  w_next = FETCH2;
            FETCH2:  w_next = FETCH3;
            FETCH3:  w_next = FETCH4;
            FETCH4:  w_next = DECODE;
            DECODE: begin
                if (op == OP_LB || op == OP_SB) w_next = MEMADR;
                else if (op == OP_RTYPE)        w_next = RTYPEEX;
                else if (op == OP_BEQ)          w_next = BEQEX;
                else if (op == OP_J)            w_next = JEX;
                else if (op == OP_ADDI)         w_next = ADDIEX;
                else                            w_next = FETCH1;
            end
            MEMADR:  w_next = r_is_store ? SBWR : LBRD;
            LBRD:    w_next = LBWR;
            RTYPEEX: w_next = RTYPEWR;
            ADDIEX:  w_next = ADDIWR;
            default: w_next = FETCH1;
        endcase
    end

    // Load/store direction is captured at decode so op is ignored afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= FETCH1;
            r_ctrl     <= f_ctrl(FETCH1);
            r_is_store <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ctrl  <= f_ctrl(w_next);
            if (r_state == DECODE) begin
                r_is_store <= (op == OP_SB);
            end
        end
    end

    always_comb begin
        w_alu = c_ALU_ADD;
        if (r_ctrl.alu_funct)    w_alu = f_alu_decode(funct);
        else if (r_ctrl.alu_sub) w_alu = c_ALU_SUB;
    end

    // Every output is gated by reset so it drops the moment reset goes low.
    assign memread    = reset & r_ctrl.memread;
    assign memwrite   = reset & r_ctrl.memwrite;
    assign alusrca    = reset & r_ctrl.alusrca;
    assign memtoreg   = reset & r_ctrl.memtoreg;
    assign regdst     = reset & r_ctrl.regdst;
    assign iord       = reset & r_ctrl.iord;
    assign regwrite   = reset & r_ctrl.regwrite;
    assign pcen       = reset & (r_ctrl.pcwrite | (r_ctrl.pcwritecond & zero));
    assign pcsrc      = {2{reset}} & r_ctrl.pcsrc;
    assign alusrcb    = {2{reset}} & r_ctrl.alusrcb;
    assign irwrite    = {4{reset}} & r_ctrl.irwrite;
    assign alucontrol = {3{reset}} & w_alu;

endmodule
`default_nettype wire

// File: tb/tb_mips8_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips8_controller
// Function : Self-checking bench for mips8_controller against an
//            instruction-level model of the expected strobe sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips8_controller;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memread, memwrite, alusrca, memtoreg, regdst, iord, pcen, regwrite;
    logic [1:0] pcsrc, alusrcb;
    logic [3:0] irwrite;
    logic [2:0] alucontrol;

    int checks   = 0;
    int failures = 0;

    mips8_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .memread    (memread),
        .memwrite   (memwrite),
        .alusrca    (alusrca),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .iord       (iord),
        .pcen       (pcen),
        .regwrite   (regwrite),
        .pcsrc      (pcsrc),
        .alusrcb    (alusrcb),
        .irwrite    (irwrite),
        .alucontrol (alucontrol)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       alusrca;
        logic       memtoreg;
        logic       regdst;
        logic       iord;
        logic       pcwrite;
        logic       pcwritecond;
        logic       regwrite;
        logic [1:0] pcsrc;
        logic [1:0] alusrcb;
        logic [3:0] irwrite;
        logic [2:0] alu;
    } step_t;

    step_t q[$];

    function automatic logic [2:0] alu_of(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Per-cycle expectations for one whole instruction, fetch to writeback.
    task automatic build(input logic [5:0] o, input logic [5:0] f);
        step_t s;
        q.delete();
        for (int n = 0; n < 4; n++) begin
            s = '0; s.memread = 1; s.irwrite = 4'(1 << n); s.alusrcb = 2'b01;
            s.pcwrite = 1; s.alu = 3'b010; q.push_back(s);
        end
        s = '0; s.alusrcb = 2'b11; s.alu = 3'b010; q.push_back(s);
        if (o == 6'b100000 || o == 6'b101000) begin
            s = '0; s.alusrca = 1; s.alusrcb = 2'b10; s.alu = 3'b010; q.push_back(s);
            if (o == 6'b100000) begin
                s = '0; s.memread = 1; s.iord = 1; s.alu = 3'b010; q.push_back(s);
                s = '0; s.regwrite = 1; s.memtoreg = 1; s.alu = 3'b010; q.push_back(s);
            end else begin
                s = '0; s.memwrite = 1; s.iord = 1; s.alu = 3'b010; q.push_back(s);
            end
        end else if (o == 6'b000000) begin
            s = '0; s.alusrca = 1; s.alu = alu_of(f); q.push_back(s);
            s = '0; s.regwrite = 1; s.regdst = 1; s.alu = 3'b010; q.push_back(s);
        end else if (o == 6'b000100) begin
            s = '0; s.alusrca = 1; s.alu = 3'b110; s.pcsrc = 2'b01; s.pcwritecond = 1;
            q.push_back(s);
        end else if (o == 6'b000010) begin
            s = '0; s.pcwrite = 1; s.pcsrc = 2'b10; s.alu = 3'b010; q.push_back(s);
        end else if (o == 6'b001000) begin
            s = '0; s.alusrca = 1; s.alusrcb = 2'b10; s.alu = 3'b010; q.push_back(s);
            s = '0; s.regwrite = 1; s.alu = 3'b010; q.push_back(s);
        end
    endtask

    // Starts and ends at posedge+1 with the DUT in FETCH1. op/funct carry
    // noise except in the cycles where they are meant to be sampled.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int abort_at,
                             input bit toggle, input string tag);
        logic [18:0] act, exp;
        build(o, f);
        for (int i = 0; i < q.size(); i++) begin
            op    = (i == 4) ? o : 6'($urandom);
            funct = (i == 5) ? f : 6'($urandom);
            zero  = 1'($urandom);
            #1;
            act = {memread, memwrite, alusrca, memtoreg, regdst, iord, pcen, regwrite,
                   pcsrc, alusrcb, irwrite, alucontrol};
            exp = {q[i].memread, q[i].memwrite, q[i].alusrca, q[i].memtoreg, q[i].regdst,
                   q[i].iord, q[i].pcwrite | (q[i].pcwritecond & zero), q[i].regwrite,
                   q[i].pcsrc, q[i].alusrcb, q[i].irwrite, q[i].alu};
            checks++;
            if (act !== exp) begin
                failures++;
                $display("FAIL %s op=%b funct=%b step=%0d: got %b expected %b",
                         tag, o, f, i, act, exp);
            end
            if (toggle && q[i].pcwritecond) begin
                for (int t = 0; t < 4; t++) begin
                    zero = ~zero;
                    #1;
                    checks++;
                    if (pcen !== zero) begin
                        failures++;
                        $display("FAIL %s pcen_follows_zero: got %b expected %b", tag, pcen, zero);
                    end
                end
            end
            if (i == abort_at) begin
                reset = 1'b0;
                #1;
                act = {memread, memwrite, alusrca, memtoreg, regdst, iord, pcen, regwrite,
                       pcsrc, alusrcb, irwrite, alucontrol};
                checks++;
                if (act !== '0) begin
                    failures++;
                    $display("FAIL %s async_reset_drop: got %b expected 0", tag, act);
                end
                @(posedge clk);
                #1;
                reset = 1'b1;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        logic [18:0] act;
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            op = 6'($urandom); funct = 6'($urandom); zero = 1'b1;
            #1;
            act = {memread, memwrite, alusrca, memtoreg, regdst, iord, pcen, regwrite,
                   pcsrc, alusrcb, irwrite, alucontrol};
            checks++;
            if (act !== '0) begin
                failures++;
                $display("FAIL reset_outputs cycle=%0d: got %b expected 0", c, act);
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
    endtask

    task automatic test_rtype();
        run_instr(6'b000000, 6'b100000, -1, 0, "rtype_add");
        run_instr(6'b000000, 6'b101010, -1, 0, "rtype_slt");
        run_instr(6'b000000, 6'b100010, -1, 0, "rtype_sub");
        run_instr(6'b000000, 6'b100100, -1, 0, "rtype_and");
        run_instr(6'b000000, 6'b100101, -1, 0, "rtype_or");
        run_instr(6'b000000, 6'b111111, -1, 0, "rtype_other");
    endtask

    task automatic test_load_store();
        run_instr(6'b100000, 6'($urandom), -1, 0, "lb");
        run_instr(6'b101000, 6'($urandom), -1, 0, "sb");
        run_instr(6'b001000, 6'($urandom), -1, 0, "addi");
    endtask

    task automatic test_branch();
        run_instr(6'b000100, 6'($urandom), -1, 1, "beq_a");
        run_instr(6'b000100, 6'($urandom), -1, 1, "beq_b");
    endtask

    task automatic test_jump_illegal();
        run_instr(6'b000010, 6'($urandom), -1, 0, "jump");
        run_instr(6'b111111, 6'($urandom), -1, 0, "illegal");
        run_instr(6'b010101, 6'($urandom), -1, 0, "illegal2");
    endtask

    task automatic test_async_reset();
        run_instr(6'b100000, 6'($urandom), 6, 0, "abort_lbrd");
        run_instr(6'b100000, 6'($urandom), -1, 0, "after_abort");
        run_instr(6'b000000, 6'b100010, 5, 0, "abort_rtypeex");
        run_instr(6'b101000, 6'($urandom), -1, 0, "after_abort2");
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [8];
        logic [5:0] fns [6];
        logic [5:0] o, f;
        ops = '{6'b100000, 6'b101000, 6'b000000, 6'b000100, 6'b000010, 6'b001000,
                6'b111111, 6'b000000};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
        for (int n = 0; n < 40; n++) begin
            o = (n % 8 == 7) ? 6'($urandom) : ops[$urandom_range(0, 6)];
            f = fns[$urandom_range(0, 5)];
            if (f == 6'b000000) f = 6'($urandom);
            run_instr(o, f, -1, 0, "random");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        op    = '0;
        funct = '0;
        zero  = 1'b0;
        test_reset();
        test_rtype();
        test_load_store();
        test_branch();
        test_jump_illegal();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips8_controller.md
Name: mips8_controller

Overview:
- Multicycle control unit for the 8-bit MIPS datapath.
- Sits directly upstream of the datapath. It consumes instr[31:26] (op), instr[5:0] (funct) and the zero flag, and drives every datapath control strobe.
- Sequences four byte-wide instruction fetches, then decode, execute, memory and writeback states.
- Moore FSM plus an embedded ALU decoder. Only pcen (via zero) and alucontrol (via funct) are combinational on inputs.

Parameters:
- OP_LB, 6'b100000, load byte opcode
- OP_SB, 6'b101000, store byte opcode
- OP_RTYPE, 6'b000000, R-type opcode
- OP_BEQ, 6'b000100, branch-equal opcode
- OP_J, 6'b000010, jump opcode
- OP_ADDI, 6'b001000, add-immediate opcode

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- op  input  6  instr[31:26] from datapath
- funct  input  6  instr[5:0] from datapath
- zero  input  1  ALU zero flag from datapath
- memread  output  1  memory read strobe
- memwrite  output  1  memory write strobe
- alusrca  output  1  ALU A select: 0 = PC, 1 = register A
- memtoreg  output  1  register write data: 0 = ALU result, 1 = memory data
- regdst  output  1  destination register: 0 = rt, 1 = rd
- iord  output  1  address select: 0 = PC, 1 = ALU result
- pcen  output  1  PC load enable = pcwrite | (pcwritecond & zero)
- regwrite  output  1  register file write enable
- pcsrc  output  2  00 = ALU, 01 = ALU result register, 10 = jump target
- alusrcb  output  2  ALU B select: 00 = B, 01 = constant 1, 10 = immediate, 11 = immediate for branch
- irwrite  output  4  one-hot instruction-register byte enable
- alucontrol  output  3  ALU operation code

Behaviour:
- State register: 4 bits. Encoding: FETCH1=0, FETCH2=1, FETCH3=2, FETCH4=3, DECODE=4, MEMADR=5, LBRD=6, LBWR=7, SBWR=8, RTYPEEX=9, RTYPEWR=10, BEQEX=11, JEX=12, ADDIEX=13, ADDIWR=14. Code 15 is unused and goes to FETCH1.
- Reset (reset=0): state forced to FETCH1 asynchronously. All outputs are forced to 0 combinationally while reset is low. The first active cycle is FETCH1 after reset rises.
- Default value of every output in every state is 0 unless listed below.
- Default aluop is add (alucontrol=010).
- FETCHn (n=1..4): memread=1, irwrite=1<<(n-1), alusrcb=01, pcwrite=1 (PC+1 per byte). FETCHn advances to FETCHn+1; FETCH4 advances to DECODE.
- DECODE: alusrcb=11 (branch target precompute). Next state by op:
  - LB/SB -> MEMADR
  - RTYPE -> RTYPEEX
  - BEQ -> BEQEX
  - J -> JEX
  - ADDI -> ADDIEX
  - any other op -> FETCH1 (illegal instruction is a no-op; no write strobes).
- MEMADR: alusrca=1, alusrcb=10. Next is LBRD for LB, SBWR for SB.
- LBRD: memread=1, iord=1. Next LBWR.
- LBWR: regwrite=1, memtoreg=1, regdst=0. Next FETCH1.
- SBWR: memwrite=1, iord=1. Next FETCH1.
- RTYPEEX: alusrca=1, alusrcb=00, alucontrol decoded from funct. Next RTYPEWR.
- RTYPEWR: regwrite=1, regdst=1, memtoreg=0. Next FETCH1.
- BEQEX: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, pcwritecond=1. pcen follows zero combinationally in this state. Next FETCH1.
- JEX: pcwrite=1, pcsrc=10. Next FETCH1.
- ADDIEX: alusrca=1, alusrcb=10, add. Next ADDIWR.
- ADDIWR: regwrite=1, regdst=0, memtoreg=0. Next FETCH1.
- ALU decode (RTYPEEX only), funct to alucontrol:
  - 100000 -> 010 (add)
  - 100010 -> 110 (sub)
  - 100100 -> 000 (and)
  - 100101 -> 001 (or)
  - 101010 -> 111 (slt)
  - any other funct -> 010
- Instruction latency, counted in cycles from FETCH1 through return to FETCH1:
  - J, BEQ: 6
  - RTYPE, ADDI, SB: 7
  - LB: 8
  - illegal op: 5
- op and funct are sampled only in DECODE and RTYPEEX. Changes in any other state have no effect.
- Reset asserted mid-instruction aborts it immediately: outputs drop to 0 in the same cycle, with no partial register or memory write after reset rises.

Test Plan:
- Reset/fetch: hold reset=0 for 3 cycles -> all outputs 0. Release -> cycles 1-4 show memread=1, pcen=1, alusrcb=01, irwrite=0001/0010/0100/1000 in order, alucontrol=010.
- R-type: op=000000 with funct=100000 -> cycle 5 alusrcb=11; cycle 6 alusrca=1, alusrcb=00, alucontrol=010; cycle 7 regwrite=1, regdst=1; cycle 8 FETCH1. Repeat with funct=101010 -> alucontrol=111 in cycle 6.
- Load/store: op=100000 -> MEMADR (alusrca=1, alusrcb=10), then LBRD (memread=1, iord=1), then LBWR (regwrite=1, memtoreg=1); FETCH1 on cycle 9. op=101000 -> SBWR memwrite=1, iord=1; regwrite never asserted.
- Branch: op=000100, zero=1 in BEQEX -> alucontrol=110, pcsrc=01, pcen=1. Rerun with zero=0 -> pcen=0. Toggling zero mid-cycle toggles pcen combinationally.
- Jump/illegal: op=000010 -> cycle 6 pcsrc=10, pcen=1. op=111111 -> FETCH1 after DECODE, with no memwrite or regwrite at any time.
- Async reset: drive reset=0 between clock edges during LBRD -> outputs 0 before the next edge. After release the first cycle is FETCH1 and no LBWR occurs.
